flag_controller: RTL

FLAG_CONTROLLER -- requirements
Module: flag_controller

---
 rtl/flag_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/flag_controller.sv
// Architectural Z/N/C flag register with a two-entry shadow stack for interrupt
// entry/return. Sequencing is a three-state IDLE/SAVE/RESTORE machine.
module flag_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       alu_we,
    input  logic [2:0] alu_flags,
    input  logic [2:0] alu_mask,
    input  logic       setc,
    input  logic       clrc,
    input  logic       int_req,
    input  logic       rti_req,
    output logic [2:0] flags,
    output logic       int_ack,
    output logic       busy,
    output logic [1:0] depth,
    output logic       stk_err
);

    // state   | meaning
    // IDLE    | accepts ALU/carry updates and interrupt requests
    // SAVE    | pushes flags onto the shadow stack, pulses int_ack
    // RESTORE | pops flags from the shadow stack
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] flags_q, flags_d;
    logic [2:0] stack_q [2];
    logic [2:0] stack_d [2];
    logic [1:0] depth_q, depth_d;
    logic       stk_err_q, stk_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flags_q    <= 3'b000;
            stack_q[0] <= 3'b000;
            stack_q[1] <= 3'b000;
            depth_q    <= 2'd0;
            stk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            stack_q[0] <= stack_d[0];
            stack_q[1] <= stack_d[1];
            depth_q    <= depth_d;
            stk_err_q  <= stk_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        stack_d[0] = stack_q[0];
        stack_d[1] = stack_q[1];
        depth_d    = depth_q;
        stk_err_d  = stk_err_q;

        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (rti_req) begin
                        state_d = RESTORE;
                    end else if (int_req) begin
                        state_d = SAVE;
                    end else begin
                        if (alu_we) begin
                            flags_d = (alu_flags & alu_mask) | (flags_q & ~alu_mask);
                        end
                        // Carry overrides apply on top of the ALU write; clear wins.
                        if (clrc) begin
                            flags_d[2] = 1'b0;
                        end else if (setc) begin
                            flags_d[2] = 1'b1;
                        end
                    end
                end
                SAVE: begin
                    if (depth_q < 2'd2) begin
                        stack_d[depth_q[0]] = flags_q;
                        depth_d             = depth_q + 2'd1;
                    end else begin
                        stk_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                RESTORE: begin
                    // Top of stack is entry depth-1, i.e. index depth_q[1] for depth 1 or 2.
                    if (depth_q != 2'd0) begin
                        flags_d = stack_q[depth_q[1]];
                        depth_d = depth_q - 2'd1;
                    end else begin
                        stk_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign flags   = flags_q;
    assign depth   = depth_q;
    assign stk_err = stk_err_q;
    assign busy    = (state_q != IDLE);
    assign int_ack = (state_q == SAVE) && !stall;

endmodule
